// File: rtl/alu_result_stage.sv
// Registered ALU result stage: condition check, flag register update, write-back packet buffer, retire counter.
// Build option: define RESULT_SKID_EN for a 2-entry buffer with registered in_ready; otherwise a single output register.
module alu_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_flags,
  input  logic [3:0]       in_sel,
  input  logic             in_set_flags,
  input  logic [3:0]       in_cond,
  input  logic [3:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_rd,
  output logic             out_we,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       rd;
    logic             we;
  } pkt_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = f;
    case (cc)
      4'h0:    res = z;
      4'h1:    res = !z;
      4'h2:    res = c;
      4'h3:    res = !c;
      4'h4:    res = n;
      4'h5:    res = !n;
      4'h6:    res = v;
      4'h7:    res = !v;
      4'h8:    res = c && !z;
      4'h9:    res = !c || z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = !z && (n == v);
      4'hD:    res = z || (n != v);
      4'hE:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic             accept;
  logic             pop;
  logic             pass;
  pkt_t             in_pkt;
  pkt_t             head;
  logic [3:0]       flags_d;
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] retire_d;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign pass   = cond_eval(in_cond, flags_q);

  always_comb begin
    in_pkt        = '0;
    in_pkt.result = in_result;
    in_pkt.rd     = in_rd;
    in_pkt.we     = pass;
  end

  // Add/sub own all four flags; every other opcode only defines N and Z.
  always_comb begin
    flags_d = flags_q;
    if (accept && pass && in_set_flags) begin
      if (in_sel == 4'b0000 || in_sel == 4'b0001) begin
        flags_d = in_flags;
      end else begin
        flags_d = {in_flags[3:2], flags_q[1:0]};
      end
    end
  end

  always_comb begin
    retire_d = retire_q;
    if (pop && head.we) begin
      retire_d = retire_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= '0;
      retire_q <= '0;
    end else begin
      flags_q  <= flags_d;
      retire_q <= retire_d;
    end
  end

  assign retire_cnt = retire_q;
  assign out_result = head.result;
  assign out_rd     = head.rd;
  assign out_we     = head.we;

`ifdef RESULT_SKID_EN

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } occ_e;

  occ_e occ_q, occ_d;
  pkt_t ent0_q, ent0_d;
  pkt_t ent1_q, ent1_d;
  logic rdy_q, rdy_d;

  assign in_ready  = rdy_q;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign head      = ent0_q;

  // ent0 is the head; an accept never arrives while full because rdy_q tracks occupancy.
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    case ({accept, pop})
      2'b10: begin
        if (occ_q == OCC_EMPTY) begin
          ent0_d = in_pkt;
          occ_d  = OCC_ONE;
        end else begin
          ent1_d = in_pkt;
          occ_d  = OCC_TWO;
        end
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
      end
      2'b11: begin
        if (occ_q == OCC_ONE) begin
          ent0_d = in_pkt;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_pkt;
        end
      end
      default: ;
    endcase
    rdy_d = (occ_d != OCC_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      ent0_q <= '0;
      ent1_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      rdy_q  <= rdy_d;
    end
  end

`else

  logic vld_q, vld_d;
  pkt_t ent0_q, ent0_d;

  assign in_ready  = !vld_q || out_ready;
  assign out_valid = vld_q;
  assign head      = ent0_q;

  always_comb begin
    vld_d  = vld_q;
    ent0_d = ent0_q;
    if (accept) begin
      vld_d  = 1'b1;
      ent0_d = in_pkt;
    end else if (pop) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      ent0_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ent0_q <= ent0_d;
    end
  end

`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: vector table plus stall, reset and counter-wrap sequences.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_flags;
  logic [3:0]  in_sel;
  logic        in_set_flags;
  logic [3:0]  in_cond;
  logic [3:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_we;
  logic [3:0]  flags_q;
  logic [15:0] retire_cnt;

  int n_pass  = 0;
  int n_total = 0;

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_sel(in_sel),
    .in_set_flags(in_set_flags), .in_cond(in_cond), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .flags_q(flags_q), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [3:0]  sel;
    logic [3:0]  fl;
    logic        sf;
    logic [3:0]  cond;
    logic [3:0]  rd;
    logic [3:0]  e_flags;
    logic        e_we;
    logic [15:0] e_ret;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] res, input logic [3:0] sel,
                              input logic [3:0] fl, input logic sf, input logic [3:0] cond,
                              input logic [3:0] rd, input logic [3:0] ef, input logic ew,
                              input logic [15:0] er);
    vec_t r;
    r.v = v; r.res = res; r.sel = sel; r.fl = fl; r.sf = sf; r.cond = cond; r.rd = rd;
    r.e_flags = ef; r.e_we = ew; r.e_ret = er;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] sel,
                       input logic [3:0] fl, input logic sf, input logic [3:0] cond,
                       input logic [3:0] rd);
    in_valid = v; in_result = res; in_sel = sel; in_flags = fl;
    in_set_flags = sf; in_cond = cond; in_rd = rd;
  endtask

  vec_t        vecs[16];
  logic [31:0] sres[3];
  logic [3:0]  srd[3];
  logic        swe[3];
  int          exp_acc;
  int          k;
  int          got;
  logic        acc_now;

  initial begin
`ifdef RESULT_SKID_EN
    exp_acc = 2;
`else
    exp_acc = 1;
`endif
    //            v  res    sel   fl    sf cond  rd    eflags we ret
    vecs[0]  = mk(1, 32'h11, 4'h1, 4'h4, 1, 4'hE, 4'h1, 4'h4, 1, 16'd0);
    vecs[1]  = mk(1, 32'h22, 4'h0, 4'h0, 0, 4'h0, 4'h2, 4'h4, 1, 16'd1);
    vecs[2]  = mk(1, 32'h33, 4'h0, 4'h3, 1, 4'hE, 4'h3, 4'h3, 1, 16'd2);
    vecs[3]  = mk(1, 32'h44, 4'h2, 4'h8, 1, 4'hE, 4'h4, 4'hB, 1, 16'd3);
    vecs[4]  = mk(1, 32'h55, 4'h0, 4'h4, 1, 4'hE, 4'h5, 4'h4, 1, 16'd4);
    vecs[5]  = mk(1, 32'h66, 4'h0, 4'h8, 1, 4'h1, 4'h6, 4'h4, 0, 16'd5);
    vecs[6]  = mk(0, 32'h0,  4'h0, 4'h0, 0, 4'hE, 4'h0, 4'h4, 0, 16'd5);
    vecs[7]  = mk(1, 32'h77, 4'h0, 4'h0, 0, 4'h8, 4'h7, 4'h4, 0, 16'd5);
    vecs[8]  = mk(1, 32'h88, 4'h0, 4'h0, 0, 4'h9, 4'h8, 4'h4, 1, 16'd5);
    vecs[9]  = mk(1, 32'h99, 4'h0, 4'h0, 0, 4'hF, 4'h9, 4'h4, 0, 16'd6);
    vecs[10] = mk(1, 32'hAA, 4'h0, 4'h0, 0, 4'hD, 4'hA, 4'h4, 1, 16'd6);
    vecs[11] = mk(1, 32'hBB, 4'h1, 4'hA, 1, 4'hE, 4'hB, 4'hA, 1, 16'd7);
    vecs[12] = mk(1, 32'hCC, 4'h3, 4'h4, 1, 4'hB, 4'hC, 4'h6, 1, 16'd8);
    vecs[13] = mk(1, 32'hDD, 4'hF, 4'h8, 1, 4'h2, 4'hD, 4'hA, 1, 16'd9);
    vecs[14] = mk(1, 32'hEE, 4'h0, 4'h0, 0, 4'h4, 4'hE, 4'hA, 1, 16'd10);
    vecs[15] = mk(0, 32'h0,  4'h0, 4'h0, 0, 4'hE, 4'h0, 4'hA, 0, 16'd11);

    sres[0] = 32'hA1; srd[0] = 4'h1; swe[0] = 1'b1;
    sres[1] = 32'hA2; srd[1] = 4'h2; swe[1] = 1'b0;
    sres[2] = 32'hA3; srd[2] = 4'h3; swe[2] = 1'b1;

    rst_n = 1'b0; out_ready = 1'b1;
    drive(0, 32'h0, 4'h0, 4'h0, 0, 4'hE, 4'h0);
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_we", out_we, 0);
    check("rst_flags", flags_q, 0);
    check("rst_retire", retire_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    // Table: one accept per cycle with out_ready high, so accept and pop overlap.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].res, vecs[i].sel, vecs[i].fl, vecs[i].sf, vecs[i].cond, vecs[i].rd);
      @(posedge clk); #1;
      check($sformatf("vec%0d_flags", i), flags_q, vecs[i].e_flags);
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].v);
      check($sformatf("vec%0d_retire", i), retire_cnt, vecs[i].e_ret);
      if (vecs[i].v) begin
        check($sformatf("vec%0d_we", i), out_we, vecs[i].e_we);
        check($sformatf("vec%0d_rd", i), out_rd, vecs[i].rd);
        check($sformatf("vec%0d_res", i), out_result, vecs[i].res);
      end
    end

    // Stall: out_ready low, three back-to-back offers.
    k = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      drive(1, sres[k], 4'h0, 4'hF, (k == 2), (swe[k] ? 4'hE : 4'hF), srd[k]);
      #1;
      acc_now = in_ready;
      if (c == 2) check("stall_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      if (acc_now) k++;
      if (k > 0) begin
        check($sformatf("stall%0d_rd", c), out_rd, srd[0]);
        check($sformatf("stall%0d_res", c), out_result, sres[0]);
        check($sformatf("stall%0d_we", c), out_we, swe[0]);
      end
    end
    check("stall_accepts", k, exp_acc);
    check("stall_flags", flags_q, 4'hA);

    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; got = 0;
    for (int c = 0; c < 8; c++) begin
      if (got < exp_acc && out_valid) begin
        check($sformatf("drain%0d_rd", got), out_rd, srd[got]);
        check($sformatf("drain%0d_res", got), out_result, sres[got]);
        check($sformatf("drain%0d_we", got), out_we, swe[got]);
        got++;
      end
      @(negedge clk);
    end
    check("drain_count", got, exp_acc);
    check("drain_valid_low", out_valid, 0);
    check("drain_retire", retire_cnt, 16'd12);

    // Asynchronous reset with packets buffered.
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 2; c++) begin
      drive(1, 32'hB0 + c, 4'h0, 4'h5, 1, 4'hE, 4'h4 + k[3:0]);
      #1;
      acc_now = in_ready;
      @(posedge clk); #1;
      if (acc_now) k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("prereset_flags", flags_q, 4'h5);
    check("prereset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", out_valid, 0);
    check("midreset_flags", flags_q, 0);
    check("midreset_retire", retire_cnt, 0);
    check("midreset_rd", out_rd, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); out_ready = 1'b1;
    drive(1, 32'h99, 4'h0, 4'h0, 0, 4'hE, 4'h9);
    @(posedge clk); #1;
    check("postreset_valid", out_valid, 1);
    check("postreset_rd", out_rd, 4'h9);
    check("postreset_res", out_result, 32'h99);
    check("postreset_flags", flags_q, 0);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("postreset_retire", retire_cnt, 16'd1);
    check("postreset_drained", out_valid, 0);

    // Retire counter wrap.
    for (int i = 0; i < 65534; i++) begin
      @(negedge clk);
      drive(1, i, 4'h0, 4'h0, 0, 4'hE, 4'h1);
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("retire_max", retire_cnt, 16'hFFFF);
    drive(1, 32'h5, 4'h0, 4'h0, 0, 4'hE, 4'h2);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("retire_wrap", retire_cnt, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
